imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Byte-stream boot loader: the write side of the instruction memory that the CPU core reads.
//  Receives a framed program over a valid/ready byte interface and writes 32-bit words to the IM write port.
//  Holds the CPU in reset until the program checksum has been verified.
//  Sits between the host/debug link and the IM write port; cpu_hold ORs into the CPU Reset.
// PARAMETERS
//  ADDR_W     10    IM word-address width
//  MAX_WORDS  1024  max program length in words; must be <= 2**ADDR_W
// PORTS
//  Clk         in   1       system clock, all state on rising edge
//  Reset       in   1       synchronous, active-high reset
//  load_start  in   1       1-cycle request to begin a load; acted on only in IDLE/DONE/ERR
//  byte_valid  in   1       source has a byte on byte_data
//  byte_data   in   8       stream byte
//  byte_ready  out  1       loader accepts byte; transfer = byte_valid & byte_ready
//  im_we       out  1       IM write strobe, 1 cycle per word
//  im_addr     out  ADDR_W  IM word address
//  im_wdata    out  32      IM write data
//  cpu_hold    out  1       1 = CPU held in reset
//  done        out  1       load verified; level, held until next load_start or Reset
//  error       out  1       load failed; level, held until next load_start or Reset
// BEHAVIOUR
//  Frame: LEN_HI, LEN_LO (N, 16-bit big-endian word count), 4*N payload bytes, CSUM.
//  Each word is big-endian: first byte -> im_wdata[31:24].
//  CSUM = 8-bit sum (mod 256) of the payload bytes only.
//  Reset: state=IDLE, cpu_hold=1, byte_ready=0, im_we=0, im_addr=0, im_wdata=0, done=0, error=0.
//  All outputs are registered.
//  FSM states: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR.
//   IDLE --load_start--> LEN_HI.
//     Next cycle: byte_ready=1, cpu_hold=1, done=0, error=0.
//     Word counter, byte index and checksum accumulator clear to 0.
//   LEN_HI --xfer--> LEN_LO.
//   LEN_LO --xfer--> DATA if 1 <= N <= MAX_WORDS; else --> ERR.
//   DATA: byte index 0..3 shifts bytes into the word register.
//     On the xfer of byte 3: im_we=1 in the following cycle, with im_addr = word counter and im_wdata = assembled word.
//     Word counter increments after the write.
//     The xfer of byte 3 of word N-1 moves the FSM to CHECK.
//   DATA/CHECK: byte_ready stays 1; a byte may be accepted in the same cycle im_we is high.
//   CHECK --xfer--> DONE if the byte equals the accumulator; else --> ERR.
//   DONE: byte_ready=0, cpu_hold=0, done=1.
//   ERR: byte_ready=0, cpu_hold=1, error=1.
//   DONE/ERR --load_start--> LEN_HI, with the same clears as IDLE.
//     cpu_hold rises the cycle after load_start.
//  load_start in LEN_HI..CHECK is ignored; the load in progress continues.
//  byte_valid=0 stalls the FSM indefinitely; no timeout.
//  im_addr holds its last value when im_we=0. im_we never asserts outside DATA/CHECK.
//  Reset mid-load: the next edge returns to reset values. A pending im_we is dropped. Written words are not undone.
//  Word counter width = ADDR_W+1, so a N=MAX_WORDS load never wraps im_addr.
// TESTING
//  1. Reset, load_start, bytes 00 01 12 34 56 78 14 -> one im_we, addr 0, data 32'h12345678; done=1, cpu_hold=0, error=0.
//  2. N=2: payload 00000001 00000002, CSUM 03 -> im_we at addr 0 then addr 1; done=1.
//  3. Same frame as 1 with CSUM 15 -> error=1, cpu_hold stays 1, done=0; the word was still written.
//  4. Length 00 00, or MAX_WORDS+1 -> ERR right after LEN_LO; no im_we; byte_ready=0.
//  5. Random byte_valid gaps plus load_start pulses mid-frame -> same writes as the gap-free run; load_start ignored.
//  6. Reset after 6 payload bytes -> all outputs at reset values next cycle. A new full load then completes with done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream in, 32-bit instruction-memory writes out.
// Keeps the CPU in reset until the payload checksum has been verified.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int CW = ADDR_W + 1;
  localparam logic [16:0] MAXW = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_t;

  state_t      state;
  logic [7:0]  len_hi;
  logic [7:0]  csum;
  logic [1:0]  idx;
  logic [23:0] word;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] last;

  logic        xfer;
  logic        restart;
  logic [15:0] n_len;
  logic        len_ok;
  logic [31:0] full_word;

  assign xfer      = byte_valid & byte_ready;
  assign restart   = load_start &&
                     (state == IDLE || state == DONE || state == ERR);
  assign n_len     = {len_hi, byte_data};
  assign len_ok    = (n_len != 16'd0) && ({1'b0, n_len} <= MAXW);
  assign full_word = {word, byte_data};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      len_hi     <= '0;
      csum       <= '0;
      idx        <= '0;
      word       <= '0;
      wcnt       <= '0;
      last       <= '0;
    end else begin
      im_we <= 1'b0;
      if (restart) begin
        state      <= LEN_HI;
        byte_ready <= 1'b1;
        cpu_hold   <= 1'b1;
        done       <= 1'b0;
        error      <= 1'b0;
        csum       <= '0;
        idx        <= '0;
        wcnt       <= '0;
      end else begin
        unique case (state)
          LEN_HI: begin
            if (xfer) begin
              len_hi <= byte_data;
              state  <= LEN_LO;
            end
          end
          LEN_LO: begin
            if (xfer) begin
              last <= CW'(n_len - 16'd1);
              if (len_ok) begin
                state <= DATA;
              end else begin
                state      <= ERR;
                byte_ready <= 1'b0;
                error      <= 1'b1;
              end
            end
          end
          DATA: begin
            if (xfer) begin
              csum <= csum + byte_data;
              word <= full_word[23:0];
              idx  <= idx + 2'd1;
              // Byte 3 completes a word: write it next cycle.
              if (idx == 2'd3) begin
                im_we    <= 1'b1;
                im_addr  <= wcnt[ADDR_W-1:0];
                im_wdata <= full_word;
                wcnt     <= wcnt + CW'(1);
                if (wcnt == last) state <= CHECK;
              end
            end
          end
          CHECK: begin
            if (xfer) begin
              byte_ready <= 1'b0;
              if (byte_data == csum) begin
                state    <= DONE;
                cpu_hold <= 1'b0;
                done     <= 1'b1;
              end else begin
                state <= ERR;
                error <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame builder model, write scoreboard,
// directed frames with hand-computed expectations.
module tb_imem_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              load_start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  typedef logic [7:0] bq_t[$];

  wr_t exp_q[$];

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .load_start(load_start),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .im_we(im_we),
    .im_addr(im_addr),
    .im_wdata(im_wdata),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error)
  );

  always #5 Clk = ~Clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Every write strobe must match the next expected write.
  always @(negedge Clk) begin
    wr_t e;
    if (im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_we: got write addr %0h data %0h expected none",
                 im_addr, im_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("we_addr", 64'(im_addr), 64'(e.a));
        chk("we_data", 64'(im_wdata), 64'(e.d));
      end
    end
  end

  function automatic bq_t frame(input logic [31:0] w[$],
                                input logic [15:0] n,
                                input logic [7:0] delta);
    bq_t q;
    logic [7:0] s;
    s = 8'h00;
    q.push_back(n[15:8]);
    q.push_back(n[7:0]);
    foreach (w[i]) begin
      for (int k = 3; k >= 0; k--) begin
        q.push_back(w[i][8*k +: 8]);
        s = s + w[i][8*k +: 8];
      end
    end
    q.push_back(s + delta);
    return q;
  endfunction

  task automatic push_words(input logic [31:0] w[$]);
    foreach (w[i]) exp_q.push_back('{a: ADDR_W'(i), d: w[i]});
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit ls);
    int t;
    byte_valid = 1'b0;
    repeat (gap) @(negedge Clk);
    byte_valid = 1'b1;
    byte_data  = b;
    load_start = ls;
    t = 0;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge Clk);
      t++;
    end
    if (byte_ready !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL byte_ready_timeout: got %b expected 1", byte_ready);
    end
    @(negedge Clk);
    load_start = 1'b0;
  endtask

  task automatic run_frame(input bq_t f, input bit gaps, input bit pulses);
    foreach (f[i])
      send(f[i], gaps ? int'($urandom_range(0, 3)) : 0,
           pulses && ($urandom_range(0, 3) == 0));
    byte_valid = 1'b0;
  endtask

  task automatic start_load(string nm);
    load_start = 1'b1;
    @(negedge Clk);
    load_start = 1'b0;
    chk(nm, 64'({byte_ready, cpu_hold, done, error}), 64'(4'b1100));
  endtask

  task automatic settle(string nm, logic [3:0] st);
    repeat (2) @(negedge Clk);
    chk({nm, "_status"}, 64'({byte_ready, cpu_hold, done, error}), 64'(st));
    chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f;
    logic [31:0] w[$];

    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("reset_outs",
        64'({byte_ready, cpu_hold, im_we, done, error, im_addr, im_wdata}),
        64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0}));
    Reset = 1'b0;
    @(negedge Clk);
    chk("idle_outs", 64'({byte_ready, cpu_hold, done, error}), 64'(4'b0100));

    // Single word, good checksum
    start_load("t1_start");
    w = '{32'h12345678};
    f = frame(w, 16'd1, 8'h00);
    chk("t1_csum_model", 64'(f[6]), 64'h14);
    exp_q.push_back('{a: 10'd0, d: 32'h12345678});
    run_frame(f, 1'b0, 1'b0);
    settle("t1", 4'b0010);
    chk("t1_addr_hold", 64'(im_addr), 64'd0);

    // Two words
    start_load("t2_start");
    w = '{32'h00000001, 32'h00000002};
    f = frame(w, 16'd2, 8'h00);
    chk("t2_csum_model", 64'(f[10]), 64'h03);
    exp_q.push_back('{a: 10'd0, d: 32'h00000001});
    exp_q.push_back('{a: 10'd1, d: 32'h00000002});
    run_frame(f, 1'b0, 1'b0);
    settle("t2", 4'b0010);

    // Bad checksum: word still written
    start_load("t3_start");
    w = '{32'h12345678};
    f = frame(w, 16'd1, 8'h01);
    chk("t3_csum_model", 64'(f[6]), 64'h15);
    push_words(w);
    run_frame(f, 1'b0, 1'b0);
    settle("t3", 4'b0101);

    // Length out of range
    start_load("t4a_start");
    f = '{8'h00, 8'h00};
    run_frame(f, 1'b0, 1'b0);
    settle("t4a", 4'b0101);
    start_load("t4b_start");
    f = '{8'h04, 8'h01};
    run_frame(f, 1'b0, 1'b0);
    settle("t4b", 4'b0101);

    // Gaps and ignored load_start pulses
    start_load("t5_start");
    w = '{32'hDEADBEEF, 32'h0BADF00D, 32'hCAFEBABE};
    f = frame(w, 16'd3, 8'h00);
    push_words(w);
    run_frame(f, 1'b1, 1'b1);
    settle("t5", 4'b0010);
    chk("t5_addr_hold", 64'(im_addr), 64'd2);

    // Full-size program, address must not wrap
    start_load("tmax_start");
    w.delete();
    for (int i = 0; i < MAX_WORDS; i++) w.push_back({16'(i), ~16'(i)});
    f = frame(w, 16'(MAX_WORDS), 8'h00);
    push_words(w);
    run_frame(f, 1'b0, 1'b0);
    settle("tmax", 4'b0010);
    chk("tmax_addr_hold", 64'(im_addr), 64'(MAX_WORDS - 1));

    // Reset mid-load, then a clean load
    start_load("t6_start");
    w = '{32'hA1B2C3D4, 32'h55667788};
    f = frame(w, 16'd2, 8'h00);
    exp_q.push_back('{a: 10'd0, d: 32'hA1B2C3D4});
    for (int i = 0; i < 8; i++) send(f[i], 0, 1'b0);
    byte_valid = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    chk("t6_reset_outs",
        64'({byte_ready, cpu_hold, im_we, done, error, im_addr, im_wdata}),
        64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0}));
    Reset = 1'b0;
    @(negedge Clk);
    start_load("t6b_start");
    push_words(w);
    run_frame(f, 1'b0, 1'b0);
    settle("t6b", 4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
